cpu_ctrl_fsm: RTL and testbench
===============================

// Module: cpu_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit for the ARMv7-subset CPU datapath. Sequences fetch, decode, execute,
//  write-back and branch phases by driving the register/latch enables and mux selects of the
//  datapath. Evaluates the ARM condition field against NZCV. Sits beside the datapath in top_CPU.
// PARAMETERS
//  COND_EN  1  1: honour Inst[31:28]; 0: treat every instruction as AL
//  LINK_EN  1  1: BL writes return address to R14; 0: BL executes as B
// PORTS
//  clk        in   1   clock, rising edge
//  Rst        in   1   asynchronous, active-high reset
//  Inst       in   32  IR contents (valid from DECODE onward)
//  NZCV       in   4   current flags {N,Z,C,V}
//  Write_PC   out  1   PC load enable
//  Write_IR   out  1   IR load enable
//  Write_Reg  out  1   register-file write enable
//  LA,LB,LC   out  1   operand latch enables (Rn, Rm, Rs)
//  LF         out  1   ALU result latch enable
//  rm_imm_s   out  1   0=Rm, 1=immediate
//  rs_imm_s   out  2   00=Rs[7:0], 01=Inst[11:7], 10={Inst[11:8],1'b0}
//  ALU_OP     out  4   ALU opcode
//  SHIFT_OP   out  3   shifter opcode
//  S          out  1   flag-update enable
//  PC_s       out  2   00=PC+4, 01=PC+4+(simm24<<2), 10/11 reserved
//  rd_s       out  1   0=Rd from Inst[15:12], 1=R14
//  ALU_A_s    out  1   0=A latch, 1=PC
//  ALU_B_s    out  1   0=shifter output, 1=constant 0
//  state      out  3   current state (debug)
// BEHAVIOUR
//  Moore FSM. State register is async reset. Outputs decode combinationally from the state and Inst.
//  Any output not listed for a state is 0.
//  Rst=1 -> IDLE immediately, at any state. All outputs are 0 while Rst is high and in IDLE.
//  IDLE  : no outputs asserted -> FETCH.
//  FETCH : Write_IR=1, Write_PC=1, PC_s=00 -> DECODE.
//  DECODE: LA=LB=LC=1.
//   - cond fails: -> FETCH.
//   - Inst[27:26]=00: -> EXEC.
//   - Inst[27:25]=101 with L=1 and LINK_EN=1: -> LINK.
//   - Inst[27:25]=101 otherwise: -> BRANCH.
//   - any other encoding: -> FETCH (NOP).
//  EXEC  : LF=1, ALU_OP=Inst[24:21], S=Inst[20], rm_imm_s=Inst[25].
//   - Inst[25]=1: rs_imm_s=10, SHIFT_OP=111.
//   - Inst[25]=0: rs_imm_s=Inst[4]?00:01, SHIFT_OP={Inst[6:5],Inst[4]}.
//   - Next: ALU_OP=10xx (TST/TEQ/CMP/CMN) -> FETCH; else -> WB.
//  WB    : Write_Reg=1, rd_s=0 -> FETCH.
//  LINK  : ALU_A_s=1, ALU_B_s=1, ALU_OP=0100 (ADD), LF=1, Write_Reg=1, rd_s=1 -> BRANCH.
//  BRANCH: Write_PC=1, PC_s=01 -> FETCH.
//  Cycles per instruction: DP 4, compare 3, failed-cond 2, B 3, BL 4.
//  Condition table is standard ARM (EQ..LE). 1110 always passes; 1111 always fails.
//  NZCV is sampled combinationally in DECODE only. Flag changes in EXEC do not alter the
//  current instruction's flow.
//  Illegal state encodings -> IDLE.
// STRUCTURE
//  cpu_ctrl_defs.vh holds the state encodings:
//   IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, LINK=5, BRANCH=6.
//  The same header holds the PC_s, rs_imm_s and ALU_OP constants and the cond codes.
//  Sub-module arm_cond_check (cond[3:0], NZCV[3:0] -> pass) is purely combinational.
// TESTING
//  1. Rst=1 for 10ns, then released:
//     - all outputs 0 during reset;
//     - state IDLE -> FETCH -> DECODE on successive edges.
//  2. Inst=E2811005 (ADD R1,R1,#5):
//     - FETCH, DECODE, EXEC (ALU_OP=0100, rm_imm_s=1, rs_imm_s=10, S=0), WB (Write_Reg=1, rd_s=0);
//     - returns to FETCH.
//  3. Inst=E1510002 (CMP R1,R2):
//     - EXEC has S=1, ALU_OP=1010, rm_imm_s=0, rs_imm_s=01, SHIFT_OP=000;
//     - no WB; FETCH follows EXEC.
//  4. Inst=0A000003 (BEQ):
//     - NZCV=0000: DECODE -> FETCH, no Write_PC beyond FETCH;
//     - NZCV=0100: BRANCH with Write_PC=1, PC_s=01.
//  5. Inst=EB000010 (BL):
//     - LINK asserts Write_Reg=1, rd_s=1, ALU_A_s=1, ALU_B_s=1;
//     - then BRANCH (PC_s=01);
//     - with LINK_EN=0 the LINK state is skipped.
//  6. Rst pulsed mid-EXEC: outputs drop to 0 asynchronously; restart from IDLE with no Write_Reg.

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared encodings for the ARMv7-subset control unit: FSM states, datapath mux selects,
// ALU/shifter opcodes and ARM condition codes.
package cpu_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_LINK   = 3'd5,
        ST_BRANCH = 3'd6
    } state_t;

    // PC source select
    localparam logic [1:0] PC_S_INC    = 2'b00;
    localparam logic [1:0] PC_S_BRANCH = 2'b01;

    // Shift-amount source select
    localparam logic [1:0] RS_IMM_RS    = 2'b00;
    localparam logic [1:0] RS_IMM_SHAMT = 2'b01;
    localparam logic [1:0] RS_IMM_ROT   = 2'b10;

    localparam logic       RD_S_INST  = 1'b0;
    localparam logic       RD_S_LR    = 1'b1;
    localparam logic       ALU_A_PC   = 1'b1;
    localparam logic       ALU_B_ZERO = 1'b1;

    localparam logic [3:0] ALU_OP_ADD       = 4'b0100;
    localparam logic [2:0] SHIFT_OP_ROR_IMM = 3'b111;

    // Instruction class fields
    localparam logic [1:0] OPC_DP     = 2'b00;
    localparam logic [2:0] OPC_BRANCH = 3'b101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // TST/TEQ/CMP/CMN only update flags and never write a register
    function automatic logic is_compare(input logic [3:0] alu_op);
        return (alu_op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition-field evaluator: decides whether an instruction with
// condition i_cond executes under the current {N,Z,C,V} flags.
module arm_cond_check
    import cpu_ctrl_fsm_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign {w_n, w_z, w_c, w_v} = i_nzcv;

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle Moore control unit for the ARMv7-subset datapath: sequences
// fetch/decode/execute/write-back/link/branch and drives datapath enables and selects.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter bit COND_EN = 1'b1,
    parameter bit LINK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [31:0] Inst,
    input  logic [3:0]  NZCV,
    output logic        Write_PC,
    output logic        Write_IR,
    output logic        Write_Reg,
    output logic        LA,
    output logic        LB,
    output logic        LC,
    output logic        LF,
    output logic        rm_imm_s,
    output logic [1:0]  rs_imm_s,
    output logic [3:0]  ALU_OP,
    output logic [2:0]  SHIFT_OP,
    output logic        S,
    output logic [1:0]  PC_s,
    output logic        rd_s,
    output logic        ALU_A_s,
    output logic        ALU_B_s,
    output logic [2:0]  state
);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] w_cond;
    logic       w_cond_pass;
    logic       w_unused;

    assign w_cond = COND_EN ? Inst[31:28] : COND_AL;

    arm_cond_check u_cond_check (
        .i_cond (w_cond),
        .i_nzcv (NZCV),
        .o_pass (w_cond_pass)
    );

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no branch of the case can infer a latch.
        w_next_state = ST_IDLE;
        Write_PC     = 1'b0;
        Write_IR     = 1'b0;
        Write_Reg    = 1'b0;
        LA           = 1'b0;
        LB           = 1'b0;
        LC           = 1'b0;
        LF           = 1'b0;
        rm_imm_s     = 1'b0;
        rs_imm_s     = RS_IMM_RS;
        ALU_OP       = 4'b0000;
        SHIFT_OP     = 3'b000;
        S            = 1'b0;
        PC_s         = PC_S_INC;
        rd_s         = RD_S_INST;
        ALU_A_s      = 1'b0;
        ALU_B_s      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
            end

            ST_FETCH: begin
                Write_IR     = 1'b1;
                Write_PC     = 1'b1;
                PC_s         = PC_S_INC;
                w_next_state = ST_DECODE;
            end

            ST_DECODE: begin
                LA = 1'b1;
                LB = 1'b1;
                LC = 1'b1;
                // Unrecognised encodings fall back to FETCH and behave as a NOP
                if (!w_cond_pass) begin
                    w_next_state = ST_FETCH;
                end else if (Inst[27:26] == OPC_DP) begin
                    w_next_state = ST_EXEC;
                end else if (Inst[27:25] == OPC_BRANCH) begin
                    w_next_state = (LINK_EN && Inst[24]) ? ST_LINK : ST_BRANCH;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_EXEC: begin
                LF       = 1'b1;
                ALU_OP   = Inst[24:21];
                S        = Inst[20];
                rm_imm_s = Inst[25];
                if (Inst[25]) begin
                    rs_imm_s = RS_IMM_ROT;
                    SHIFT_OP = SHIFT_OP_ROR_IMM;
                end else begin
                    rs_imm_s = Inst[4] ? RS_IMM_RS : RS_IMM_SHAMT;
                    SHIFT_OP = Inst[6:4];
                end
                w_next_state = is_compare(Inst[24:21]) ? ST_FETCH : ST_WB;
            end

            ST_WB: begin
                Write_Reg    = 1'b1;
                rd_s         = RD_S_INST;
                w_next_state = ST_FETCH;
            end

            // Return address = PC + 0 written to R14 before the branch target is loaded
            ST_LINK: begin
                ALU_A_s      = ALU_A_PC;
                ALU_B_s      = ALU_B_ZERO;
                ALU_OP       = ALU_OP_ADD;
                LF           = 1'b1;
                Write_Reg    = 1'b1;
                rd_s         = RD_S_LR;
                w_next_state = ST_BRANCH;
            end

            ST_BRANCH: begin
                Write_PC     = 1'b1;
                PC_s         = PC_S_BRANCH;
                w_next_state = ST_FETCH;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign state = r_state;

    // Operand/register fields are consumed by the datapath, not the controller
    assign w_unused = ^{Inst[19:7], Inst[3:0]};

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: a per-instruction phase model pushes expected per-cycle
// output vectors; a negedge monitor pops and compares against the selected DUT instance.
module tb_cpu_ctrl_fsm;

    typedef struct packed {
        logic       wpc;
        logic       wir;
        logic       wreg;
        logic       la;
        logic       lb;
        logic       lc;
        logic       lf;
        logic       rmi;
        logic [1:0] rsi;
        logic [3:0] aluop;
        logic [2:0] shop;
        logic       s;
        logic [1:0] pcs;
        logic       rds;
        logic       alua;
        logic       alub;
        logic [2:0] st;
    } ov_t;

    localparam logic [2:0] P_IDLE = 3'd0, P_FETCH = 3'd1, P_DECODE = 3'd2, P_EXEC = 3'd3,
                           P_WB = 3'd4, P_LINK = 3'd5, P_BRANCH = 3'd6;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [31:0] Inst;
    logic [3:0]  NZCV;
    logic        sel_b;

    logic        a_wpc, a_wir, a_wreg, a_la, a_lb, a_lc, a_lf, a_rmi, a_s, a_rds, a_alua, a_alub;
    logic [1:0]  a_rsi, a_pcs;
    logic [3:0]  a_aluop;
    logic [2:0]  a_shop, a_st;
    logic        b_wpc, b_wir, b_wreg, b_la, b_lb, b_lc, b_lf, b_rmi, b_s, b_rds, b_alua, b_alub;
    logic [1:0]  b_rsi, b_pcs;
    logic [3:0]  b_aluop;
    logic [2:0]  b_shop, b_st;

    ov_t act_a, act_b, act;

    ov_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  m_cond_en;
    bit  m_link_en;

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.COND_EN(1'b1), .LINK_EN(1'b1)) dut (
        .clk(clk), .Rst(rst_a), .Inst(Inst), .NZCV(NZCV),
        .Write_PC(a_wpc), .Write_IR(a_wir), .Write_Reg(a_wreg),
        .LA(a_la), .LB(a_lb), .LC(a_lc), .LF(a_lf),
        .rm_imm_s(a_rmi), .rs_imm_s(a_rsi), .ALU_OP(a_aluop), .SHIFT_OP(a_shop), .S(a_s),
        .PC_s(a_pcs), .rd_s(a_rds), .ALU_A_s(a_alua), .ALU_B_s(a_alub), .state(a_st)
    );

    cpu_ctrl_fsm #(.COND_EN(1'b0), .LINK_EN(1'b0)) dut_b (
        .clk(clk), .Rst(rst_b), .Inst(Inst), .NZCV(NZCV),
        .Write_PC(b_wpc), .Write_IR(b_wir), .Write_Reg(b_wreg),
        .LA(b_la), .LB(b_lb), .LC(b_lc), .LF(b_lf),
        .rm_imm_s(b_rmi), .rs_imm_s(b_rsi), .ALU_OP(b_aluop), .SHIFT_OP(b_shop), .S(b_s),
        .PC_s(b_pcs), .rd_s(b_rds), .ALU_A_s(b_alua), .ALU_B_s(b_alub), .state(b_st)
    );

    assign act_a = {a_wpc, a_wir, a_wreg, a_la, a_lb, a_lc, a_lf, a_rmi, a_rsi, a_aluop,
                    a_shop, a_s, a_pcs, a_rds, a_alua, a_alub, a_st};
    assign act_b = {b_wpc, b_wir, b_wreg, b_la, b_lb, b_lc, b_lf, b_rmi, b_rsi, b_aluop,
                    b_shop, b_s, b_pcs, b_rds, b_alua, b_alub, b_st};
    assign act   = sel_b ? act_b : act_a;

    task automatic check(input string name, input ov_t got, input ov_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h (state %0d) expected %h (state %0d)",
                     name, $time, got, got.st, want, want.st);
        end
    endtask

    // ARM condition rule: even codes test a predicate, odd codes its inverse; 111x is AL/NV
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        if (!m_cond_en) return 1'b1;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c == 4'b1110);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic ov_t exp_for(input logic [2:0] ph, input logic [31:0] inst);
        ov_t o;
        o    = '0;
        o.st = ph;
        case (ph)
            P_FETCH:  begin o.wir = 1'b1; o.wpc = 1'b1; end
            P_DECODE: begin o.la = 1'b1; o.lb = 1'b1; o.lc = 1'b1; end
            P_EXEC: begin
                o.lf    = 1'b1;
                o.aluop = inst[24:21];
                o.s     = inst[20];
                o.rmi   = inst[25];
                if (inst[25]) begin
                    o.rsi  = 2'b10;
                    o.shop = 3'b111;
                end else begin
                    o.rsi  = inst[4] ? 2'b00 : 2'b01;
                    o.shop = {inst[6:5], inst[4]};
                end
            end
            P_WB:     o.wreg = 1'b1;
            P_LINK:   begin o.alua = 1'b1; o.alub = 1'b1; o.aluop = 4'd4; o.lf = 1'b1;
                            o.wreg = 1'b1; o.rds = 1'b1; end
            P_BRANCH: begin o.wpc = 1'b1; o.pcs = 2'b01; end
            default:  ;
        endcase
        return o;
    endfunction

    // Called in the FETCH cycle; queues the whole instruction's phase trace and waits it out
    task automatic run_instr(input logic [31:0] inst, input logic [3:0] flags);
        logic [2:0] ph[$];
        Inst = inst;
        NZCV = flags;
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        if (cond_ok(inst[31:28], flags)) begin
            if (inst[27:26] == 2'b00) begin
                ph.push_back(P_EXEC);
                if (!(inst[24:21] >= 4'd8 && inst[24:21] <= 4'd11)) ph.push_back(P_WB);
            end else if (inst[27:25] == 3'b101) begin
                if (inst[24] && m_link_en) ph.push_back(P_LINK);
                ph.push_back(P_BRANCH);
            end
        end
        foreach (ph[i]) exp_q.push_back(exp_for(ph[i], inst));
        repeat (ph.size()) @(posedge clk);
        #1;
    endtask

    // Leaves the selected instance in FETCH, 1ns after the edge
    task automatic do_reset(input bit which);
        sel_b = which;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check("rst_async_zero", act, '0);
        @(posedge clk);
        #1;
        check("rst_hold_zero", act, '0);
        @(negedge clk);
        if (which) rst_b = 1'b0;
        else       rst_a = 1'b0;
        #2;
        check("idle_after_rst", act, exp_for(P_IDLE, 32'h0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] inst;
        logic [2:0]  other[5];
        other   = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
        inst    = $urandom;
        inst[31:28] = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
        case ($urandom_range(0, 5))
            0, 1, 2: inst[27:26] = 2'b00;
            3, 4:    inst[27:25] = 3'b101;
            default: inst[27:25] = other[$urandom_range(0, 4)];
        endcase
        return inst;
    endfunction

    initial begin : monitor
        ov_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("trace", act, e);
            end
        end
    end

    initial begin : stim
        Inst      = 32'h0;
        NZCV      = 4'h0;
        m_cond_en = 1'b1;
        m_link_en = 1'b1;

        do_reset(1'b0);
        run_instr(32'hE2811005, 4'h0);   // ADD R1,R1,#5
        run_instr(32'hE1510002, 4'h0);   // CMP R1,R2
        run_instr(32'h0A000003, 4'h0);   // BEQ not taken
        run_instr(32'h0A000003, 4'h4);   // BEQ taken
        run_instr(32'hEB000010, 4'h0);   // BL
        run_instr(32'hF2811005, 4'h0);   // NV never executes
        run_instr(32'hE1A00312, 4'h0);   // MOV R0,R2,LSL R3 (register shift)

        // Reset pulsed in the middle of EXEC
        Inst = 32'hE2811005;
        NZCV = 4'h0;
        exp_q.push_back(exp_for(P_FETCH, Inst));
        exp_q.push_back(exp_for(P_DECODE, Inst));
        repeat (2) @(posedge clk);
        #1;
        check("exec_before_rst", act, exp_for(P_EXEC, Inst));
        #2;
        do_reset(1'b0);
        run_instr(32'hE2811005, 4'h0);

        for (int i = 0; i < 300; i++) run_instr(rand_instr(), 4'($urandom_range(0, 15)));

        // Second instance: conditions ignored, BL executes as B
        m_cond_en = 1'b0;
        m_link_en = 1'b0;
        do_reset(1'b1);
        run_instr(32'hEB000010, 4'h0);
        run_instr(32'h0A000003, 4'h0);
        run_instr(32'hF1510002, 4'h0);
        for (int i = 0; i < 150; i++) run_instr(rand_instr(), 4'($urandom_range(0, 15)));

        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
